// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write channels of the instruction encoder.
// The master side issues field-level requests and accepts memory writes.
interface instr_encoder_if #(
  parameter int AW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_op;
  logic [1:0]    in_rd;
  logic [1:0]    in_rs1;
  logic [1:0]    in_rs2;
  logic [6:0]    in_alu_op;
  logic [15:0]   in_imm;
  logic          in_br_sel;
  logic          in_br_val;
  logic          imem_we;
  logic          imem_ready;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_alu_op, in_imm,
           in_br_sel, in_br_val, imem_ready,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_alu_op, in_imm,
           in_br_sel, in_br_val, imem_ready,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs field-level instruction requests into 16-bit words, range-checks them,
// and streams them through a small FIFO into sequential instruction-memory addresses.
module instr_encoder #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  instr_encoder_if.slave bus,
  output logic [AW:0]   count,
  output logic          err,
  output logic [1:0]    err_code
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [15:0]   data_mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic [AW-1:0] addr_cnt;
  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic [15:0]   word;
  logic [15:0]   off;
  logic          legal;
  logic [1:0]    code;

  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  assign bus.in_ready   = !full && !start;
  assign bus.imem_we    = !empty;
  assign bus.imem_addr  = addr_mem[rd_ptr[PW-1:0]];
  assign bus.imem_wdata = data_mem[rd_ptr[PW-1:0]];

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && legal;
  assign pop    = !empty && bus.imem_ready && !start;

  // Branch offset is relative to the address this word will occupy; it fits
  // in 8 signed bits only when bits [15:7] are a pure sign extension.
  always_comb begin
    word  = '0;
    legal = 1'b1;
    code  = 2'b00;
    off   = bus.in_imm - {{(16-AW){1'b0}}, addr_cnt};
    case (bus.in_op)
      3'b000: word = {3'b000, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_alu_op};
      3'b001: begin
        word = {3'b001, bus.in_rd, 3'b000, bus.in_imm[7:0]};
        if (bus.in_imm[15:8] != 8'h00) begin
          legal = 1'b0;
          code  = 2'b10;
        end
      end
      3'b011: word = {3'b011, bus.in_rd, bus.in_rs1, 9'b0};
      3'b101: word = {3'b101, 2'b00, bus.in_rs1, bus.in_rs2, 7'b0};
      3'b110: begin
        word = {3'b110, bus.in_br_sel, bus.in_br_val, 3'b000, off[7:0]};
        if ((off[15:7] != 9'h000) && (off[15:7] != 9'h1FF)) begin
          legal = 1'b0;
          code  = 2'b11;
        end
      end
      default: begin
        legal = 1'b0;
        code  = 2'b01;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr[PW-1:0]] <= addr_cnt;
      data_mem[wr_ptr[PW-1:0]] <= word;
    end
  end

  // start overrides every other event: flush, reload and clear in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      addr_cnt <= '0;
      count    <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else if (start) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      addr_cnt <= base_addr;
      count    <= '0;
      err      <= 1'b0;
      err_code <= 2'b00;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        addr_cnt <= addr_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (count != '1)
          count <= count + 1'b1;
      end
      if (accept && !legal) begin
        err <= 1'b1;
        if (!err)
          err_code <= code;
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios followed by random
// traffic, compared every cycle against a queue-based reference model.
module tb_instr_encoder;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [2:0]  op;
    logic [1:0]  rd;
    logic [1:0]  rs1;
    logic [1:0]  rs2;
    logic [6:0]  alu;
    logic [15:0] imm;
    logic        sel;
    logic        val;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count;
  logic          err;
  logic [1:0]    err_code;

  instr_encoder_if #(.AW(AW)) bus ();

  instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .bus(bus), .count(count), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_addr[$];
  int exp_data[$];
  int m_a = 0;
  int m_count = 0;
  int m_err = 0;
  int m_code = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference encoding from the ISA field layout; code 0 means legal.
  function automatic int refEncode(input req_t r, input int a, output int code);
    int op, rd, rs1, rs2, alu, imm, sel, val, off, w;
    op = int'(r.op); rd = int'(r.rd); rs1 = int'(r.rs1); rs2 = int'(r.rs2);
    alu = int'(r.alu); imm = int'(r.imm); sel = int'(r.sel); val = int'(r.val);
    code = 0;
    w = 0;
    case (op)
      0: w = rd * 2048 + rs1 * 512 + rs2 * 128 + alu;
      1: if (imm > 255) code = 2; else w = 1 * 8192 + rd * 2048 + imm;
      3: w = 3 * 8192 + rd * 2048 + rs1 * 512;
      5: w = 5 * 8192 + rs1 * 512 + rs2 * 128;
      6: begin
        off = imm - a;
        if (off >= 32768) off = off - 65536;
        if (off < -128 || off > 127) code = 3;
        else w = 6 * 8192 + sel * 4096 + val * 2048 + (off & 255);
      end
      default: code = 1;
    endcase
    return w;
  endfunction

  function automatic req_t mk(input int op, input int rd, input int rs1, input int rs2,
                              input int alu, input int imm, input int sel, input int val);
    req_t r;
    r.op = 3'(op); r.rd = 2'(rd); r.rs1 = 2'(rs1); r.rs2 = 2'(rs2);
    r.alu = 7'(alu); r.imm = 16'(imm); r.sel = 1'(sel); r.val = 1'(val);
    return r;
  endfunction

  // Drive one cycle of inputs, check outputs against the model, then advance
  // the model and the clock to the next falling edge.
  task automatic applyStimulus(input logic st, input logic [AW-1:0] base, input logic vld,
                               input req_t r, input logic rdy);
    bit m_ready;
    int w, code;
    start = st; base_addr = base; bus.in_valid = vld;
    bus.in_op = r.op; bus.in_rd = r.rd; bus.in_rs1 = r.rs1; bus.in_rs2 = r.rs2;
    bus.in_alu_op = r.alu; bus.in_imm = r.imm; bus.in_br_sel = r.sel; bus.in_br_val = r.val;
    bus.imem_ready = rdy;
    #1;
    m_ready = (exp_addr.size() < DEPTH) && !st;
    checkOutput("in_ready", 32'(bus.in_ready), 32'(m_ready));
    checkOutput("imem_we", 32'(bus.imem_we), 32'(exp_addr.size() > 0));
    if (exp_addr.size() > 0) begin
      checkOutput("imem_addr", 32'(bus.imem_addr), exp_addr[0]);
      checkOutput("imem_wdata", 32'(bus.imem_wdata), exp_data[0]);
    end
    checkOutput("count", 32'(count), m_count);
    checkOutput("err", 32'(err), m_err);
    checkOutput("err_code", 32'(err_code), m_code);
    if (st) begin
      exp_addr.delete(); exp_data.delete();
      m_a = int'(base); m_count = 0; m_err = 0; m_code = 0;
    end else begin
      if (exp_addr.size() > 0 && rdy) begin
        void'(exp_addr.pop_front()); void'(exp_data.pop_front());
        if (m_count < (1 << (AW + 1)) - 1) m_count++;
      end
      if (vld && m_ready) begin
        w = refEncode(r, m_a, code);
        if (code == 0) begin
          exp_addr.push_back(m_a); exp_data.push_back(w);
          m_a = (m_a + 1) % (1 << AW);
        end else begin
          if (m_err == 0) m_code = code;
          m_err = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, '0, 1'b0, '0, rdy);
  endtask

  initial begin
    req_t r;
    int pick, mode;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_alu_op = '0; bus.in_imm = '0; bus.in_br_sel = 1'b0; bus.in_br_val = 1'b0;
    bus.imem_ready = 1'b0;
    #12;
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_err_code", 32'(err_code), 0);
    checkOutput("rst_imem_we", 32'(bus.imem_we), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 32'(bus.in_ready), 1);

    // ALU word at base 0x10
    applyStimulus(1'b1, 8'h10, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, mk(0, 1, 2, 3, 5, 0, 0, 0), 1'b1);
    checkOutput("alu_we", 32'(bus.imem_we), 1);
    checkOutput("alu_addr", 32'(bus.imem_addr), 32'h10);
    checkOutput("alu_word", 32'(bus.imem_wdata), 32'h0D85);
    idle(1'b1);
    checkOutput("alu_count", 32'(count), 1);

    // LD immediate legal, then out of range, then next word stays sequential
    applyStimulus(1'b0, '0, 1'b1, mk(1, 2, 0, 0, 0, 16'h00AB, 0, 0), 1'b1);
    checkOutput("ld_word", 32'(bus.imem_wdata), 32'h30AB);
    checkOutput("ld_addr", 32'(bus.imem_addr), 32'h11);
    applyStimulus(1'b0, '0, 1'b1, mk(1, 2, 0, 0, 0, 16'h0100, 0, 0), 1'b1);
    checkOutput("ld_err", 32'(err), 1);
    checkOutput("ld_err_code", 32'(err_code), 2);
    applyStimulus(1'b0, '0, 1'b1, mk(5, 0, 1, 2, 0, 0, 0, 0), 1'b1);
    checkOutput("after_err_addr", 32'(bus.imem_addr), 32'h12);
    idle(1'b1);

    // Branches: backward in range, then +128 out of range
    applyStimulus(1'b1, 8'h20, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, mk(6, 0, 0, 0, 0, 16'h0010, 1, 0), 1'b1);
    checkOutput("br_word", 32'(bus.imem_wdata), 32'hD0F0);
    applyStimulus(1'b0, '0, 1'b1, mk(6, 0, 0, 0, 0, 16'h00A1, 1, 0), 1'b1);
    checkOutput("br_err_code", 32'(err_code), 3);
    checkOutput("br_no_write", 32'(bus.imem_we), 0);

    // Backpressure: fill the FIFO, hold, then drain
    applyStimulus(1'b1, 8'h40, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, '0, 1'b1, mk(3, i, i, 0, 0, 0, 0, 0), 1'b0);
    checkOutput("full_in_ready", 32'(bus.in_ready), 0);
    applyStimulus(1'b0, '0, 1'b1, mk(0, 3, 3, 3, 7'h7F, 0, 0, 0), 1'b0);
    idle(1'b0);
    checkOutput("stall_addr", 32'(bus.imem_addr), 32'h40);
    for (int i = 0; i <= DEPTH; i++) idle(1'b1);
    checkOutput("drain_count", 32'(count), DEPTH);

    // Illegal opcodes keep the first error code; start clears it
    applyStimulus(1'b1, 8'h00, 1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, mk(2, 1, 1, 1, 1, 0, 0, 0), 1'b1);
    applyStimulus(1'b0, '0, 1'b1, mk(7, 1, 1, 1, 1, 0, 0, 0), 1'b1);
    checkOutput("illegal_code", 32'(err_code), 1);
    checkOutput("illegal_no_write", 32'(bus.imem_we), 0);
    applyStimulus(1'b1, 8'h00, 1'b0, '0, 1'b1);
    checkOutput("start_clr_err", 32'(err), 0);
    checkOutput("start_clr_code", 32'(err_code), 0);

    // Flush a full FIFO with start, then wrap the address counter
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, '0, 1'b1, mk(0, i, 0, 0, i, 0, 0, 0), 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b1, mk(0, 1, 1, 1, 1, 0, 0, 0), 1'b1);
    checkOutput("flush_we", 32'(bus.imem_we), 0);
    checkOutput("flush_count", 32'(count), 0);
    applyStimulus(1'b0, '0, 1'b1, mk(3, 1, 2, 0, 0, 0, 0, 0), 1'b1);
    checkOutput("wrap_addr_ff", 32'(bus.imem_addr), 32'hFF);
    applyStimulus(1'b0, '0, 1'b1, mk(3, 2, 1, 0, 0, 0, 0, 0), 1'b1);
    checkOutput("wrap_addr_00", 32'(bus.imem_addr), 32'h00);
    idle(1'b1);

    // Random traffic including illegal opcodes and near-range branches
    for (int n = 0; n < 800; n++) begin
      pick = $urandom_range(0, 7);
      r.op = 3'(pick);
      r.rd = 2'($urandom); r.rs1 = 2'($urandom); r.rs2 = 2'($urandom);
      r.alu = 7'($urandom); r.sel = 1'($urandom); r.val = 1'($urandom);
      mode = $urandom_range(0, 2);
      if (mode == 0) r.imm = 16'($urandom_range(0, 300));
      else if (mode == 1) r.imm = 16'($urandom);
      else r.imm = 16'(m_a + $urandom_range(0, 300) - 150);
      applyStimulus($urandom_range(0, 39) == 0, AW'($urandom), $urandom_range(0, 3) != 0,
                    r, $urandom_range(0, 9) < 7);
    end
    for (int i = 0; i <= DEPTH; i++) idle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
